aes_core_scheduler: RTL and testbench
=====================================

Name: aes_core_scheduler

Overview:
- Shares one byte-serial AES_encryption core between NREQ requesters, each presenting a 128-bit key and plaintext block.
- Round-robin arbitration picks one requester. The block then resets the core, streams in 16 key/state byte pairs, waits for completion and collects the 16 ciphertext bytes into a 128-bit result.
- Returns a per-requester done pulse, or an error pulse on timeout.
- Sits between the requesters and the core; it is the only driver of the core's inputs.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 512, maximum cycles allowed in WAIT plus UNLOAD before the job is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- req  in  NREQ  request per requester; level, held until done/err.
- key_in  in  NREQ*128  key of requester n at [128n+127:128n].
- blk_in  in  NREQ*128  plaintext of requester n at [128n+127:128n].
- gnt  out  NREQ  one-hot grant, high for the whole job.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle timeout pulse, coincident with the gnt bit still high.
- result  out  128  ciphertext; valid on the done cycle, held until the next done.
- busy  out  1  high in every state except IDLE.
- core_rst  out  1  active-high reset to the core.
- core_enable  out  1  enable to the core.
- core_key_byte  out  8  key byte to the core.
- core_state_byte  out  8  state byte to the core.
- core_ready  in  1  core output-byte strobe.
- core_out_byte  in  8  core ciphertext byte.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0, except core_rst=1.
  - State goes to IDLE; rr_ptr=NREQ-1, so req[0] has highest priority first.
  - Byte/timeout counters cleared.
  - Reset mid-job abandons the job with no done or err.
- IDLE:
  - core_enable=0, core_rst=0.
  - If any req is set, the winner is the first set bit searching from rr_ptr+1 upward, wrapping.
  - Latch the winner's key/blk into internal registers, set gnt one-hot and rr_ptr=winner, then go to CLR.
- CLR (2 cycles): core_rst=1, core_enable=0; clears the core's load and output counters. Then go to LOAD.
- LOAD (exactly 16 cycles, k=0..15):
  - core_enable=1, core_rst=0.
  - core_key_byte=key[127-8k -: 8] and core_state_byte=blk[127-8k -: 8], i.e. MSB byte first.
  - Bytes are registered, so byte k appears on cycle k of LOAD.
  - After the 16th cycle go to WAIT.
- WAIT:
  - core_enable held at 1.
  - Timeout counter increments every cycle.
  - When core_ready=1, capture that byte as byte 0 and go to UNLOAD.
- UNLOAD:
  - On each cycle with core_ready=1, capture core_out_byte into res[8m+7:8m], where m is the capture index 0..15 (LSB byte first). The result is exactly the core's 128-bit state.
  - Cycles with core_ready=0 are ignored but still count toward the timeout.
  - After the 16th capture go to RESP.
- RESP (1 cycle):
  - result<=res; done[winner]=1 for this cycle; core_enable=0.
  - Next cycle: gnt=0, return to IDLE.
- Timeout:
  - If the counter reaches TIMEOUT in WAIT or UNLOAD, pulse err=1 for one cycle and go to CLR_ABORT.
  - CLR_ABORT holds core_rst=1 for one cycle, then goes to IDLE with gnt cleared.
  - result is unchanged; done is not pulsed.
- Arbitration rules:
  - A requester that drops req mid-job is ignored; the job completes and done still pulses.
  - A new req arriving while busy waits.
  - A requester must drop req on the cycle after done; if it stays high, it is re-eligible at the next IDLE arbitration behind the other requesters.
- Latency:
  - From req seen in IDLE to the first core byte: 3 cycles (IDLE, CLR x2).
  - Throughput is bounded by the core; back-to-back jobs need 1 IDLE cycle between them.
- gnt is never multi-hot, and at most one of done/err pulses per job.

Test Plan:
- FIPS-197 vector on req[0]: key=000102030405060708090a0b0c0d0e0f, blk=00112233445566778899aabbccddeeff -> gnt=01; core_key_byte sequence 00,01,...,0f; done[0] pulses once; result=69c4e0d86a7b0430d8cdb78070b4c55a; busy falls the cycle after done.
- req=11 in the same cycle after reset -> req[0] served first, then req[1]. The second job on req[1] uses key 2b7e151628aed2a6abf7158809cf4f3c, blk 3243f6a8885a308d313198a2e0370734 -> result 3925841d02dc09fbdc118597196a0b32.
- req[0] and req[1] held permanently high -> grants alternate 01,10,01,10 for 4 jobs; never two consecutive grants to the same requester.
- Core model that never raises core_ready, TIMEOUT=64 -> err pulses exactly 64 cycles after WAIT entry; core_rst=1 for 1 cycle; done stays 0; result unchanged; next req is served normally.
- rst driven low during LOAD byte 7 -> next cycle all outputs 0, core_rst=1; after release, a new request completes with the correct result.
- core_ready gaps (ready low 3 cycles between bytes 5 and 6) -> all 16 bytes captured in order; result is still correct.

Source files
------------

// File: rtl/aes_core_scheduler.sv
// rtl/aes_core_scheduler.sv - round-robin scheduler sharing one byte-serial AES core
// Purpose: arbitrates NREQ requesters onto a single byte-serial AES core.
//          For each job it resets the core, streams 16 key/state byte pairs
//          (MSB byte first), then collects 16 ciphertext bytes (LSB byte
//          first) into a 128-bit result. If the job times out, err pulses
//          instead of done.
// Ports:   clk, rst (sync, active-low)
//          req/key_in/blk_in : requester side, 128-bit slice per requester
//          gnt/done/err/result/busy : requester-side status
//          core_rst/core_enable/core_key_byte/core_state_byte : core drive
//          core_ready/core_out_byte : core ciphertext byte strobe
module aes_core_scheduler #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*128-1:0]  key_in,
    input  logic [NREQ*128-1:0]  blk_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [127:0]         result,
    output logic                 busy,
    output logic                 core_rst,
    output logic                 core_enable,
    output logic [7:0]           core_key_byte,
    output logic [7:0]           core_state_byte,
    input  logic                 core_ready,
    input  logic [7:0]           core_out_byte
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;
    localparam logic [2:0] S_ABORT  = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    blk_q, blk_d;
    logic [127:0]    res_q, res_d;
    logic [127:0]    result_q, result_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            core_rst_q, core_rst_d;
    logic            core_en_q, core_en_d;
    logic [7:0]      kbyte_q, kbyte_d;
    logic [7:0]      sbyte_q, sbyte_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [IW-1:0]   idx;
    logic [127:0]    res_shift;
    logic            tmo_hit;
    logic            last_cap;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = {1'b0, rr_q} + IW'(i);
            if (idx >= IW'(NREQ)) begin
                idx = idx - IW'(NREQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    // Captured bytes enter at the top and walk down, so capture m ends at [8m+7:8m].
    assign res_shift = {core_out_byte, res_q[127:8]};
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign last_cap  = core_ready && (cnt_q == 4'd15);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        key_d    = key_q;
        blk_d    = blk_q;
        res_d    = res_q;
        result_d = result_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        kbyte_d  = 8'h00;
        sbyte_d  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    rr_d       = win;
                    key_d      = key_in[128*win +: 128];
                    blk_d      = blk_in[128*win +: 128];
                    cnt_d      = '0;
                    state_d    = S_CLR;
                end
            end
            S_CLR: begin
                if (cnt_q == 4'd1) begin
                    // Present byte 0 on the first LOAD cycle; shift registers feed the rest.
                    kbyte_d = key_q[127:120];
                    sbyte_d = blk_q[127:120];
                    key_d   = {key_q[119:0], 8'h00};
                    blk_d   = {blk_q[119:0], 8'h00};
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_LOAD: begin
                if (cnt_q == 4'd15) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    kbyte_d = key_q[127:120];
                    sbyte_d = blk_q[127:120];
                    key_d   = {key_q[119:0], 8'h00};
                    blk_d   = {blk_q[119:0], 8'h00};
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else if (core_ready) begin
                    res_d   = res_shift;
                    cnt_d   = 4'd1;
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                tmo_d = tmo_q + TW'(1);
                if (core_ready) begin
                    res_d = res_shift;
                    cnt_d = cnt_q + 4'd1;
                end
                // A final byte landing on the timeout cycle still completes the job.
                if (last_cap) begin
                    result_d = res_shift;
                    done_d   = gnt_q;
                    state_d  = S_RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end
            end
            S_RESP: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Core controls are registered from the next state so they line up with it.
    assign core_en_d  = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_UNLOAD);
    assign core_rst_d = (state_d == S_CLR) || (state_d == S_ABORT);
    assign busy_d     = (state_d != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rr_q       <= PW'(NREQ - 1);
            cnt_q      <= '0;
            tmo_q      <= '0;
            key_q      <= '0;
            blk_q      <= '0;
            res_q      <= '0;
            result_q   <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            kbyte_q    <= 8'h00;
            sbyte_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            key_q      <= key_d;
            blk_q      <= blk_d;
            res_q      <= res_d;
            result_q   <= result_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
            kbyte_q    <= kbyte_d;
            sbyte_q    <= sbyte_d;
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign err             = err_q;
    assign result          = result_q;
    assign busy            = busy_q;
    assign core_rst        = core_rst_q;
    assign core_enable     = core_en_q;
    assign core_key_byte   = kbyte_q;
    assign core_state_byte = sbyte_q;
endmodule

// File: tb/tb_aes_core_scheduler.sv
// tb/tb_aes_core_scheduler.sv - scoreboard bench for aes_core_scheduler with an AES-128 core model
module tb_aes_core_scheduler;
    localparam int NREQ = 3;
    localparam int TMO  = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*128-1:0] key_in;
    logic [NREQ*128-1:0] blk_in;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [127:0]        result;
    logic                busy;
    logic                core_rst;
    logic                core_enable;
    logic [7:0]          core_key_byte;
    logic [7:0]          core_state_byte;
    logic                core_ready = 1'b0;
    logic [7:0]          core_out_byte = 8'h00;

    always #5 clk = ~clk;

    aes_core_scheduler #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .key_in(key_in), .blk_in(blk_in),
        .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
        .core_rst(core_rst), .core_enable(core_enable),
        .core_key_byte(core_key_byte), .core_state_byte(core_state_byte),
        .core_ready(core_ready), .core_out_byte(core_out_byte)
    );

    logic [127:0] key_r [NREQ];
    logic [127:0] blk_r [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign key_in[128*g +: 128] = key_r[g];
        assign blk_in[128*g +: 128] = blk_r[g];
    end

    typedef struct {
        int           id;
        logic [127:0] res;
        bit           is_err;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    // ---------------- AES-128 reference (FIPS-197) ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] rk [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w0, w1, w2, w3, tmp, rc, a0, a1, a2, a3;
        logic [127:0] c;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[127-8*i -: 8];
            s[i]  = p[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            w0 = rk[i-4]; w1 = rk[i-3]; w2 = rk[i-2]; w3 = rk[i-1];
            if (i % 16 == 0) begin
                tmp = w0;
                w0 = sbox[w1] ^ rc; w1 = sbox[w2]; w2 = sbox[w3]; w3 = sbox[tmp];
                rc = xt(rc);
            end
            rk[i] = rk[i-16] ^ w0; rk[i+1] = rk[i-15] ^ w1;
            rk[i+2] = rk[i-14] ^ w2; rk[i+3] = rk[i-13] ^ w3;
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r < 10) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) c[127-8*i -: 8] = s[i];
        return c;
    endfunction

    // ---------------- byte-serial core model ----------------
    bit never_ready = 1'b0;
    int cfg_lat = 3;
    int cfg_gap = 0;
    int lcnt = 0, ocnt = 0, lat = 0, gap_left = 0;
    logic [127:0] kacc = '0, sacc = '0, ct = '0;

    always @(negedge clk) begin
        core_ready    = 1'b0;
        core_out_byte = 8'h00;
        if (!rst || core_rst) begin
            lcnt = 0; ocnt = 0; lat = 0; gap_left = 0;
        end else if (core_enable) begin
            if (lcnt < 16) begin
                kacc = {kacc[119:0], core_key_byte};
                sacc = {sacc[119:0], core_state_byte};
                lcnt++;
                if (lcnt == 16) begin
                    ct = aes_enc(kacc, sacc);
                    lat = cfg_lat; gap_left = cfg_gap; ocnt = 0;
                end
            end else if (!never_ready && ocnt < 16) begin
                if (lat > 0) lat--;
                else if (ocnt == 6 && gap_left > 0) gap_left--;
                else begin
                    core_ready    = 1'b1;
                    core_out_byte = ct[8*ocnt +: 8];
                    ocnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0, en_rise = 0;
    bit prev_en = 1'b0, post_evt = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic [NREQ-1:0] oh;
        cyc++;
        if (rst) begin
            chk("gnt_onehot0", 128'($onehot0(gnt)), 128'd1);
            if (post_evt) begin
                chk("after_evt_busy", 128'(busy), 128'd0);
                chk("after_evt_gnt", 128'(gnt), 128'd0);
                chk("after_evt_core_rst", 128'(core_rst), 128'd0);
            end
            post_evt = 1'b0;
            if (core_enable && !prev_en) en_rise = cyc;
            if (|done || err) begin
                post_evt = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 128'({done, err}), 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("evt_gnt", 128'(gnt), 128'(oh));
                    chk("evt_done", 128'(done), e.is_err ? 128'd0 : 128'(oh));
                    chk("evt_err", 128'(err), 128'(e.is_err));
                    chk("evt_result", result, e.res);
                    chk("evt_busy", 128'(busy), 128'd1);
                    if (e.is_err) begin
                        chk("err_latency", 128'(cyc - en_rise), 128'(16 + TMO));
                        chk("err_core_rst", 128'(core_rst), 128'd1);
                    end
                end
            end
        end else begin
            post_evt = 1'b0;
        end
        prev_en = core_enable;
    end

    // ---------------- reference arbitration and driver ----------------
    int mrr = NREQ - 1;
    logic [127:0] m_last = '0;

    function automatic int next_winner(int ptr, logic [NREQ-1:0] p);
        int j;
        for (int i = 1; i <= NREQ; i++) begin
            j = (ptr + i) % NREQ;
            if (p[j]) return j;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rst_gnt", 128'(gnt), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_result", result, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_core_rst", 128'(core_rst), 128'd1);
        chk("rst_core_enable", 128'(core_enable), 128'd0);
        chk("rst_key_byte", 128'(core_key_byte), 128'd0);
        chk("rst_state_byte", 128'(core_state_byte), 128'd0);
        @(negedge clk);
        exp_q.delete();
        mrr = NREQ - 1;
        m_last = '0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_jobs(input logic [NREQ-1:0] r, input bit hold, input int njobs);
        logic [NREQ-1:0] p;
        exp_t e;
        int w, seen, budget;
        p = r;
        for (int j = 0; j < njobs; j++) begin
            w = next_winner(mrr, p);
            if (!never_ready) m_last = aes_enc(key_r[w], blk_r[w]);
            e.id = w; e.is_err = never_ready; e.res = m_last;
            exp_q.push_back(e);
            mrr = w;
            if (!hold) p[w] = 1'b0;
        end
        @(negedge clk);
        req = r;
        seen = 0;
        budget = 0;
        while ((exp_q.size() != 0 || busy || req != '0) && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (|done || err) begin
                seen++;
                if (hold) begin
                    if (seen == njobs) req = '0;
                end else begin
                    req = req & ~(done | (err ? gnt : '0));
                end
            end
        end
        if (budget >= 3000) begin
            n_cmp++; n_fail++;
            $display("FAIL job_timeout: %0d events pending after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
            req = '0;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int en_cnt;
        logic [NREQ-1:0] r;
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            key_r[i] = '0;
            blk_r[i] = '0;
        end
        build_sbox();
        do_reset();

        // FIPS-197 vector on requester 0
        key_r[0] = 128'h000102030405060708090a0b0c0d0e0f;
        blk_r[0] = 128'h00112233445566778899aabbccddeeff;
        run_jobs(3'b001, 1'b0, 1);
        chk("fips_key_sequence", kacc, key_r[0]);
        chk("fips_blk_sequence", sacc, blk_r[0]);
        chk("fips_result", result, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Two simultaneous requests straight after reset: 0 then 1
        do_reset();
        key_r[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        blk_r[1] = 128'h3243f6a8885a308d313198a2e0370734;
        run_jobs(3'b011, 1'b0, 2);
        chk("second_vector_result", result, 128'h3925841d02dc09fbdc118597196a0b32);

        // Requests held high: grants alternate over four jobs
        run_jobs(3'b011, 1'b1, 4);

        // Core never answers: timeout then normal service
        never_ready = 1'b1;
        run_jobs(3'b010, 1'b0, 1);
        never_ready = 1'b0;
        key_r[2] = rnd128();
        blk_r[2] = rnd128();
        run_jobs(3'b100, 1'b0, 1);

        // Reset during LOAD byte 7
        key_r[0] = rnd128();
        blk_r[0] = rnd128();
        @(negedge clk);
        req = 3'b001;
        en_cnt = 0;
        for (int t = 0; t < 100 && en_cnt < 8; t++) begin
            @(negedge clk);
            if (core_enable) en_cnt++;
        end
        chk("load_byte7_key", 128'(core_key_byte), 128'(key_r[0][71:64]));
        chk("load_byte7_blk", 128'(core_state_byte), 128'(blk_r[0][71:64]));
        do_reset();
        key_r[0] = rnd128();
        run_jobs(3'b001, 1'b0, 1);

        // Ready gap of 3 cycles between bytes 5 and 6
        cfg_gap = 3;
        key_r[1] = rnd128();
        blk_r[1] = rnd128();
        run_jobs(3'b010, 1'b0, 1);

        // Randomized request sets, latencies and gaps
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                key_r[i] = rnd128();
                blk_r[i] = rnd128();
            end
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            cfg_lat = $urandom_range(0, 6);
            cfg_gap = $urandom_range(0, 3);
            run_jobs(r, 1'b0, $countones(r));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
